ex_branch_resolve: RTL and testbench
====================================

# ex_branch_resolve

Execute-stage back end of the RISC-V core, directly downstream of the ALU. It takes the ALU `Result` and its N/Z/C/V flags together with the instruction's control and PC fields, and resolves branches and jumps from those flags. It registers the write-back payload into a valid/ready stage toward write-back. It issues a one-cycle PC redirect, squashes the younger instructions already in flight, and halts on a misaligned control-flow target.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `FLUSH_SLOTS`, 2, number of younger accepted instructions dropped after a redirect (1..7).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: the ALU stage presents an instruction.
- `in_ready` out 1: this stage accepts the instruction this cycle.
- `Result` in XLEN: ALU result. For branches it is the subtraction A−B; for JALR it is rs1+imm.
- `N`, `Z`, `C`, `V` in 1 each: ALU flags of the subtraction. C is the carry out of A+~B+1.
- `pc` in XLEN: PC of the instruction.
- `imm` in XLEN: sign-extended immediate.
- `is_branch`, `is_jal`, `is_jalr` in 1 each: one-hot or all zero.
- `br_type` in 3: funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
- `rd` in 5: destination register.
- `reg_write` in 1: the instruction writes `rd`.
- `out_valid` out 1: write-back payload is valid.
- `out_ready` in 1: write-back accepts the payload.
- `wb_data` out XLEN: data to write back.
- `wb_rd` out 5: destination register for write-back.
- `wb_we` out 1: write enable for write-back.
- `redirect` out 1: one-cycle pulse requesting a fetch redirect.
- `redirect_pc` out XLEN: new fetch PC, valid while `redirect` is high.
- `trap` out 1: sticky misaligned-target trap.
- `trap_pc` out XLEN: PC of the faulting instruction.

## Operation
- Accept condition: `in_valid & in_ready`.
  - `in_ready = (state != TRAP) & (~out_valid | out_ready)`.
- Branch taken conditions:
  - BEQ: Z. BNE: ~Z.
  - BLT: N^V. BGE: ~(N^V).
  - BLTU: ~C. BGEU: C.
  - `br_type` values 010 and 011 are never taken.
- Target address:
  - Branch and JAL: `pc+imm`, modulo 2^XLEN.
  - JALR: `Result & ~1`.
- Redirect:
  - Taken = (is_branch & condition) | is_jal | is_jalr.
  - A taken instruction with target bit 1 clear registers `redirect=1` and `redirect_pc=target`.
- Write-back data:
  - JAL/JALR: `wb_data = pc+4`. All other instructions: `wb_data = Result`.
  - `wb_we = reg_write & (rd != 0)`. Branches always present `wb_we = 0`.
  - Every accepted, non-squashed, non-trapping instruction produces exactly one `out_valid` beat, including branches.
- FSM states:
  - RUN: normal operation.
    - A taken, aligned instruction loads `sq_cnt = FLUSH_SLOTS` and moves to SQUASH.
    - A taken instruction with a misaligned target (bit 1 set) moves to TRAP.
  - SQUASH: each accepted beat is consumed and discarded; it produces no output, no redirect and no trap.
    - Each accepted beat decrements `sq_cnt`.
    - At 0, return to RUN. The transition takes effect on the edge of the last squashed accept.
    - With no accepts, the counter holds.
  - TRAP: `trap=1`, `trap_pc` holds the faulting PC, `in_ready=0`, no further redirects.
    - Only reset exits TRAP.
    - An output beat already pending completes normally.
- Boundary rules:
  - A taken branch arriving in SQUASH is dropped and does not restart the counter.
  - A misaligned target arriving in SQUASH is dropped and does not trap.
  - If `out_valid & ~out_ready`, the output holds stable and `in_ready = 0`.
  - Reset mid-SQUASH or mid-TRAP returns to RUN with `sq_cnt = 0`.

## Timing
- Latency is 1 cycle: an instruction accepted at edge k appears on `out_valid` and `wb_*` after edge k.
- `redirect` is high for exactly the one cycle after the accepting edge, independent of `out_ready`.
- `trap` rises the cycle after the accepting edge and stays high.
- Full throughput: one accept per cycle when `out_ready = 1`.
- The stage holds at most one entry; there is no internal buffering beyond the output register.
- Reset values:
  - `out_valid=0`, `redirect=0`, `trap=0`.
  - `wb_data=0`, `wb_rd=0`, `wb_we=0`, `redirect_pc=0`, `trap_pc=0`.
  - `state=RUN`, `sq_cnt=0`.

## Test plan
- BEQ with Z=1, pc=0x100, imm=0x20:
  - `redirect` pulses once with `redirect_pc=0x120`.
  - Output beat has `wb_we=0`.
  - The next 2 accepted beats produce no `out_valid`; the 3rd does.
- BLTU/BGEU with C=0, then with C=1:
  - BLTU is taken only when C=0; BGEU is taken only when C=1.
  - BLT with N=1, V=1 is not taken.
- JALR with Result=0x2003, pc=0x40, rd=1:
  - `redirect_pc=0x2002`, then TRAP with `trap_pc=0x40`, `in_ready=0`.
  - Assert `rst` low: `trap=0` and acceptance resumes.
- JAL with pc=0x80, imm=0x10, rd=5:
  - `wb_data=0x84`, `wb_rd=5`, `wb_we=1`, `redirect_pc=0x90`.
  - The same with rd=0 gives `wb_we=0`.
- Backpressure:
  - Hold `out_ready=0` for 3 cycles with `in_valid=1`: `in_ready=0`, the output stays stable, and no beat is lost or duplicated.
  - Release `out_ready`: 1 beat/cycle.
- Taken branch presented during SQUASH is dropped without redirect.
- `rst` asserted with `sq_cnt=1` clears squash, and the next instruction is output.

Source files
------------

// File: rtl/ex_branch_resolve_if.sv
// ----------------------------------------------------------------------------
// ex_branch_resolve_if
// Bundles the signals between the ALU stage, ex_branch_resolve, the write-back
// stage and the fetch unit.
//   ALU side   : in_valid/in_ready handshake, Result, N/Z/C/V flags, pc, imm,
//                is_branch/is_jal/is_jalr, br_type, rd, reg_write
//   WB side    : out_valid/out_ready handshake, wb_data, wb_rd, wb_we
//   Fetch side : redirect, redirect_pc, trap, trap_pc
// The master modport is the environment that drives instructions and accepts
// results. The slave modport is the execute back end itself.
// ----------------------------------------------------------------------------
interface ex_branch_resolve_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] Result;
   logic            N;
   logic            Z;
   logic            C;
   logic            V;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] imm;
   logic            is_branch;
   logic            is_jal;
   logic            is_jalr;
   logic [2:0]      br_type;
   logic [4:0]      rd;
   logic            reg_write;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] wb_data;
   logic [4:0]      wb_rd;
   logic            wb_we;

   logic            redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            trap;
   logic [XLEN-1:0] trap_pc;

   modport master (
      output in_valid, Result, N, Z, C, V, pc, imm,
             is_branch, is_jal, is_jalr, br_type, rd, reg_write, out_ready,
      input  in_ready, out_valid, wb_data, wb_rd, wb_we,
             redirect, redirect_pc, trap, trap_pc
   );

   modport slave (
      input  in_valid, Result, N, Z, C, V, pc, imm,
             is_branch, is_jal, is_jalr, br_type, rd, reg_write, out_ready,
      output in_ready, out_valid, wb_data, wb_rd, wb_we,
             redirect, redirect_pc, trap, trap_pc
   );
endinterface

// File: rtl/ex_branch_resolve.sv
// ----------------------------------------------------------------------------
// ex_branch_resolve
// Execute-stage back end. It resolves branches from the ALU flags of A-B and
// computes the jump or branch targets. It registers the write-back payload in a
// single-entry valid/ready stage. It also pulses a fetch redirect for taken
// control flow, discards the next FLUSH_SLOTS accepted (wrong-path)
// instructions, and halts with a sticky trap on a target whose bit 1 is set.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - ex_branch_resolve_if.slave (ALU input, WB output, redirect/trap)
// ----------------------------------------------------------------------------
module ex_branch_resolve #(
   parameter int XLEN        = 32,
   parameter int FLUSH_SLOTS = 2    // 1..7
) (
   input  logic                 clk,
   input  logic                 rst,
   ex_branch_resolve_if.slave   bus
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      SQUASH = 2'd1,
      TRAP   = 2'd2
   } state_t;

   localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_SLOTS);

   state_t          state;
   logic [2:0]      sq_cnt;
   logic            cond;
   logic            taken;
   logic            misaligned;
   logic            accept;
   logic [XLEN-1:0] target;

   // Branch condition from the flags of A-B. C is the no-borrow carry,
   // so unsigned A<B is ~C.
   always_comb begin
      // NOTE: default first so every path assigns cond and no latch is inferred.
      cond = 1'b0;
      case (bus.br_type)
         3'b000:  cond = bus.Z;
         3'b001:  cond = ~bus.Z;
         3'b100:  cond = bus.N ^ bus.V;
         3'b101:  cond = ~(bus.N ^ bus.V);
         3'b110:  cond = ~bus.C;
         3'b111:  cond = bus.C;
         default: cond = 1'b0;
      endcase
   end

   assign target     = bus.is_jalr ? {bus.Result[XLEN-1:1], 1'b0} : bus.pc + bus.imm;
   assign taken      = (bus.is_branch & cond) | bus.is_jal | bus.is_jalr;
   assign misaligned = target[1];

   assign bus.in_ready = (state != TRAP) & (~bus.out_valid | bus.out_ready);
   assign accept       = bus.in_valid & bus.in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= RUN;
         sq_cnt          <= 3'd0;
         bus.out_valid   <= 1'b0;
         bus.wb_data     <= '0;
         bus.wb_rd       <= 5'd0;
         bus.wb_we       <= 1'b0;
         bus.redirect    <= 1'b0;
         bus.redirect_pc <= '0;
         bus.trap        <= 1'b0;
         bus.trap_pc     <= '0;
      end else begin
         // NOTE: non-blocking assignments. A later assignment in this block
         // overrides these defaults on the same edge.
         bus.redirect <= 1'b0;
         if (bus.out_valid && bus.out_ready)
            bus.out_valid <= 1'b0;

         if (accept) begin
            case (state)
               RUN: begin
                  if (taken && misaligned) begin
                     // The faulting instruction produces no beat and no redirect.
                     state           <= TRAP;
                     bus.trap        <= 1'b1;
                     bus.trap_pc     <= bus.pc;
                     bus.redirect_pc <= target;
                  end else begin
                     bus.out_valid <= 1'b1;
                     bus.wb_data   <= (bus.is_jal | bus.is_jalr) ? bus.pc + XLEN'(4) : bus.Result;
                     bus.wb_rd     <= bus.rd;
                     bus.wb_we     <= ~bus.is_branch & bus.reg_write & (bus.rd != 5'd0);
                     if (taken) begin
                        bus.redirect    <= 1'b1;
                        bus.redirect_pc <= target;
                        sq_cnt          <= FLUSH_CNT;
                        state           <= SQUASH;
                     end
                  end
               end
               SQUASH: begin
                  // Wrong-path beat: consumed silently, including any control flow.
                  sq_cnt <= sq_cnt - 3'd1;
                  if (sq_cnt == 3'd1)
                     state <= RUN;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_branch_resolve.sv
module tb_ex_branch_resolve;
   localparam int XLEN  = 32;
   localparam int FLUSH = 2;

   typedef enum {K_ALU, K_BR, K_JAL, K_JALR} kind_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ex_branch_resolve_if #(.XLEN(XLEN)) bus ();

   ex_branch_resolve #(.XLEN(XLEN), .FLUSH_SLOTS(FLUSH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: the architectural view of the stage.
   bit          m_valid;
   logic [31:0] m_data;
   logic [4:0]  m_rd;
   bit          m_we;
   bit          m_redirect;
   logic [31:0] m_rpc;
   bit          m_trap;
   logic [31:0] m_tpc;
   int          m_squash;

   // Instruction currently presented, in operand terms.
   kind_t       c_kind;
   logic [31:0] c_a, c_b, c_pc, c_imm, c_result;
   logic [2:0]  c_f;
   logic [4:0]  c_rd;
   bit          c_rw;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit br_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) <  $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a <  b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   // The instruction is given as operands. For branches the flags are produced the way
   // the ALU would compute them from A-B. For JALR, a=rs1 and b=imm.
   task automatic set_instr(input kind_t k, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic [2:0] f, input logic [4:0] rd, input bit rw);
      logic [32:0] s;
      c_kind = k; c_a = a; c_b = b; c_pc = pc; c_f = f; c_rd = rd; c_rw = rw;
      c_imm  = (k == K_JALR) ? b : imm;
      s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      case (k)
         K_BR:    c_result = s[31:0];
         K_JALR:  c_result = a + b;
         default: c_result = a;
      endcase
      bus.Result    = c_result;
      bus.pc        = pc;
      bus.imm       = c_imm;
      bus.br_type   = f;
      bus.rd        = rd;
      bus.reg_write = rw;
      bus.is_branch = (k == K_BR);
      bus.is_jal    = (k == K_JAL);
      bus.is_jalr   = (k == K_JALR);
      if (k == K_BR) begin
         bus.N = s[31];
         bus.Z = (s[31:0] == 32'd0);
         bus.C = s[32];
         bus.V = (a[31] != b[31]) && (s[31] != a[31]);
      end else begin
         {bus.N, bus.Z, bus.C, bus.V} = 4'($urandom);
      end
   endtask

   task automatic check_outputs();
      check("out_valid", bus.out_valid, m_valid);
      check("redirect",  bus.redirect,  m_redirect);
      check("trap",      bus.trap,      m_trap);
      check("trap_pc",   bus.trap_pc,   m_tpc);
      if (m_valid) begin
         check("wb_data", bus.wb_data, m_data);
         check("wb_rd",   bus.wb_rd,   m_rd);
         check("wb_we",   bus.wb_we,   m_we);
      end
      if (m_redirect)
         check("redirect_pc", bus.redirect_pc, m_rpc);
   endtask

   // One clock cycle. The model advances across the edge, then the DUT is sampled at edge+1.
   task automatic cycle(input bit iv, input bit ordy);
      bit          rdy, acc, tk;
      logic [31:0] tgt;
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      #1;
      rdy = !m_trap && (!m_valid || ordy);
      check("in_ready", bus.in_ready, rdy);
      acc = iv && rdy;
      if (m_valid && ordy) m_valid = 0;
      m_redirect = 0;
      if (acc) begin
         if (m_squash > 0) begin
            m_squash--;
         end else begin
            tk  = (c_kind == K_JAL) || (c_kind == K_JALR) ||
                  ((c_kind == K_BR) && br_taken(c_f, c_a, c_b));
            tgt = (c_kind == K_JALR) ? ((c_a + c_b) & ~32'd1) : c_pc + c_imm;
            if (tk && tgt[1]) begin
               m_trap = 1; m_tpc = c_pc; m_rpc = tgt;
            end else begin
               m_valid = 1;
               m_data  = (c_kind == K_JAL || c_kind == K_JALR) ? c_pc + 32'd4 : c_result;
               m_rd    = c_rd;
               m_we    = (c_kind != K_BR) && c_rw && (c_rd != 5'd0);
               if (tk) begin
                  m_redirect = 1; m_rpc = tgt; m_squash = FLUSH;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      m_valid = 0; m_redirect = 0; m_trap = 0; m_squash = 0;
      m_data = '0; m_rd = '0; m_we = 0; m_rpc = '0; m_tpc = '0;
      check("rst_out_valid",   bus.out_valid,   1'b0);
      check("rst_redirect",    bus.redirect,    1'b0);
      check("rst_trap",        bus.trap,        1'b0);
      check("rst_wb_data",     bus.wb_data,     32'd0);
      check("rst_wb_rd",       bus.wb_rd,       5'd0);
      check("rst_wb_we",       bus.wb_we,       1'b0);
      check("rst_redirect_pc", bus.redirect_pc, 32'd0);
      check("rst_trap_pc",     bus.trap_pc,     32'd0);
      check("rst_in_ready",    bus.in_ready,    1'b1);
      rst = 1'b1;
   endtask

   task automatic alu(input logic [31:0] v, input logic [4:0] rd);
      set_instr(K_ALU, v, 32'd0, 32'h1000, 32'd0, 3'd0, rd, 1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < FLUSH; i++) begin
         alu(32'hDEAD_0000 + i, 5'd9);
         cycle(1, 1);
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      alu(32'd0, 5'd0);
      #2;
      do_reset();

      // BEQ taken: redirect to 0x120, then two beats are squashed and the third is output.
      set_instr(K_BR, 32'd5, 32'd5, 32'h100, 32'h20, 3'd0, 5'd3, 1'b1);
      cycle(1, 1);
      check("beq_redirect_pc", bus.redirect_pc, 32'h120);
      check("beq_wb_we", bus.wb_we, 1'b0);
      alu(32'h11, 5'd4); cycle(1, 1);
      check("beq_sq1_valid", bus.out_valid, 1'b0);
      alu(32'h22, 5'd4); cycle(1, 1);
      check("beq_sq2_valid", bus.out_valid, 1'b0);
      alu(32'h33, 5'd4); cycle(1, 1);
      check("beq_third_valid", bus.out_valid, 1'b1);

      // BLTU / BGEU with C=0 then C=1, and BLT with N=1, V=1.
      set_instr(K_BR, 32'd3, 32'd7, 32'h200, 32'h40, 3'd6, 5'd0, 1'b0); cycle(1, 1);
      check("bltu_c0_taken", bus.redirect, 1'b1);
      drain();
      set_instr(K_BR, 32'd7, 32'd3, 32'h200, 32'h40, 3'd6, 5'd0, 1'b0); cycle(1, 1);
      check("bltu_c1_taken", bus.redirect, 1'b0);
      set_instr(K_BR, 32'd3, 32'd7, 32'h200, 32'h40, 3'd7, 5'd0, 1'b0); cycle(1, 1);
      check("bgeu_c0_taken", bus.redirect, 1'b0);
      set_instr(K_BR, 32'd7, 32'd3, 32'h200, 32'h40, 3'd7, 5'd0, 1'b0); cycle(1, 1);
      check("bgeu_c1_taken", bus.redirect, 1'b1);
      drain();
      set_instr(K_BR, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h200, 32'h40, 3'd4, 5'd0, 1'b0); cycle(1, 1);
      check("blt_nv_taken", bus.redirect, 1'b0);

      // JAL with rd=5 and with rd=0.
      set_instr(K_JAL, 32'd0, 32'd0, 32'h80, 32'h10, 3'd0, 5'd5, 1'b1); cycle(1, 1);
      check("jal_wb_data", bus.wb_data, 32'h84);
      check("jal_rpc", bus.redirect_pc, 32'h90);
      drain();
      set_instr(K_JAL, 32'd0, 32'd0, 32'h80, 32'h10, 3'd0, 5'd0, 1'b1); cycle(1, 1);
      check("jal_rd0_we", bus.wb_we, 1'b0);
      drain();

      // Backpressure: the output holds and input is stalled, then one beat per cycle.
      alu(32'hA1, 5'd6); cycle(1, 1);
      alu(32'hB2, 5'd7);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0);
         check("bp_hold_data", bus.wb_data, 32'hA1);
      end
      cycle(1, 1);
      alu(32'hC3, 5'd8); cycle(1, 1);
      alu(32'hD4, 5'd8); cycle(1, 1);

      // A taken branch inside the squash window is dropped and does not restart the count.
      set_instr(K_BR, 32'd1, 32'd1, 32'h300, 32'h8, 3'd0, 5'd0, 1'b0); cycle(1, 1);
      set_instr(K_BR, 32'd1, 32'd2, 32'h304, 32'h8, 3'd1, 5'd0, 1'b0); cycle(1, 1);
      check("sq_branch_redirect", bus.redirect, 1'b0);
      alu(32'hE5, 5'd2); cycle(1, 1);
      alu(32'hF6, 5'd2); cycle(1, 1);
      check("sq_after_valid", bus.out_valid, 1'b1);

      // Reset with one squash slot left: the next instruction is output.
      set_instr(K_JAL, 32'd0, 32'd0, 32'h400, 32'h20, 3'd0, 5'd1, 1'b1); cycle(1, 1);
      alu(32'h77, 5'd3); cycle(1, 1);
      do_reset();
      alu(32'h88, 5'd3); cycle(1, 1);
      check("rst_sq_valid", bus.out_valid, 1'b1);

      // JALR to a misaligned target traps and stalls until reset.
      set_instr(K_JALR, 32'h2000, 32'h3, 32'h40, 32'd0, 3'd0, 5'd1, 1'b1); cycle(1, 1);
      check("jalr_rpc", bus.redirect_pc, 32'h2002);
      check("jalr_trap_pc", bus.trap_pc, 32'h40);
      alu(32'h99, 5'd3); cycle(1, 1);
      check("trap_in_ready", bus.in_ready, 1'b0);
      do_reset();
      alu(32'hAA, 5'd3); cycle(1, 1);
      check("post_trap_valid", bus.out_valid, 1'b1);

      // Randomized traffic checked against the model.
      for (int i = 0; i < 600; i++) begin
         kind_t       k;
         logic [31:0] imm, a;
         k   = kind_t'($urandom_range(0, 3));
         imm = {$urandom_range(0, 1) ? 20'hFFFFF : 20'h0, 12'($urandom_range(0, 1023) << 2)};
         if ($urandom_range(0, 15) == 0) imm = imm | 32'd2;
         a = $urandom;
         if (k == K_JALR && $urandom_range(0, 7) != 0) a = a & ~32'd2;
         if (k == K_BR && $urandom_range(0, 3) == 0) a = 32'h5555;
         set_instr(k, a, (k == K_JALR) ? imm : ((k == K_BR && a == 32'h5555) ? 32'h5555 : $urandom),
                   $urandom & ~32'd3, imm, 3'($urandom), 5'($urandom), 1'($urandom));
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         if (m_trap && $urandom_range(0, 3) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
